tick_generator_multi: RTL and testbench
=======================================

Name: tick_generator_multi

Overview:
Multi-channel, runtime-programmable successor to the single fixed-rate tick divider. Each of NUM_CH channels produces a one-cycle enable pulse (Tick) every Divisor clock cycles. Each channel also produces a toggling square-wave Level. Sits between the system clock domain and slow consumers: display scan, human-visible CPU stepping, UART/LED demo timing. Adds per-channel enable, single-step, and glitch-free divisor reprogramming.

Parameters:
NUM_CH, 4, number of independent tick channels (1..16)
CNT_W, 32, counter/divisor width in bits
DEFAULT_DIV, 100_000_000, divisor loaded into every channel at reset (must fit CNT_W)

Ports:
Clock  in  1  system clock
Reset  in  1  asynchronous, active-high reset
Enable  in  NUM_CH  per-channel run enable
Step  in  NUM_CH  per-channel single-step request, honoured only while that channel's Enable=0
CfgWrite  in  1  divisor write strobe
CfgChannel  in  $clog2(NUM_CH) (min 1)  target channel of CfgWrite
CfgDivisor  in  CNT_W  new divisor value
Tick  out  NUM_CH  one-cycle pulse per period
Level  out  NUM_CH  toggles on every Tick of that channel
DivActive  out  NUM_CH*CNT_W  currently applied divisor per channel, packed channel 0 in LSBs

Behaviour:
- Reset (async, Clock ignored):
  - every counter=0; Tick=0; Level=0
  - DivActive and shadow divisor = DEFAULT_DIV for each channel
  - pending-load flags cleared
- Effective divisor D = max(DivActive, 1). D=0 and D=1 both give Tick every cycle while enabled.
- Enabled channel:
  - counter counts 0..D-1, then wraps to 0.
  - Tick is registered: high for exactly the one cycle after the counter reaches D-1; low otherwise.
  - Period is exactly D cycles.
  - First Tick after Enable rises occurs D cycles later (counter starts from 0).
- Disabled channel:
  - counter held at 0; Tick=0; Level holds its value.
- Step[i]=1 with Enable[i]=0:
  - Tick[i]=1 on the next cycle, Level[i] toggles, counter unchanged.
  - Step held high yields one Tick per cycle; no edge detection (the caller debounces).
- Step[i] with Enable[i]=1: ignored.
- CfgWrite:
  - CfgDivisor is captured into channel CfgChannel's shadow register and its pending flag is set.
  - CfgChannel >= NUM_CH: write ignored.
- Shadow → DivActive transfer (glitch-free):
  - enabled channel: at the wrap cycle, i.e. the same edge that asserts Tick. The current period always completes with the old divisor.
  - disabled channel: on the next cycle.
  - pending flag clears on transfer.
- Second CfgWrite to the same channel before transfer: overwrites the shadow (last write wins).
- CfgWrite in the same cycle as that channel's wrap:
  - the value is not used for the period starting now; it applies at the following wrap.
  - any earlier pending value transfers now.
- Enable falling mid-period: counter returns to 0 next cycle; no Tick for the partial period.
- Channels are fully independent; no shared state except the config port.

Optional Feature:
Macro TICKGEN_SYNC_EN.
- Defined: adds input SyncStart (1 bit). SyncStart=1 forces every channel counter to 0 next cycle and suppresses any Tick that would fire that cycle. Pending divisors transfer at the same edge. Used to phase-align channels.
- Undefined: no port; behaviour exactly as above.

Decomposition:
Package tickgen_pkg holds:
- parameter-independent constants: default CNT_W, DEFAULT_DIV
- typedef tickgen_mode_t (reserved enum: PULSE, LEVEL)
- function eff_div() implementing max(d,1)

Natural sub-module tick_channel: one counter, shadow, pending flag, Tick/Level logic. Instantiated NUM_CH times by a generate loop; the top decodes the config port and fans out Sync.

Test Plan:
1. Reset with DEFAULT_DIV=10, Enable=4'b0001 → Tick[0] high exactly at cycles 10, 20, 30 after release; Tick[3:1]=0; Level[0] toggles each Tick.
2. Ch0 running D=10; CfgWrite ch0 D=4 at cycle 13 → next Tick at cycle 20 (old period completes), then at 24, 28.
3. Ch1 D=0 and D=1, enabled → Tick[1] high every cycle; DivActive reads 0 and 1 respectively.
4. Ch2 disabled, Step[2] pulsed 3 single cycles → exactly 3 Ticks, each 1 cycle after its Step, Level[2] ends at 1. Step[2] with Enable[2]=1 → no extra Tick.
5. Assert Reset mid-period (counter=7 of D=10, pending write of 3) → all outputs 0 immediately; DivActive back to DEFAULT_DIV; pending discarded.
6. With TICKGEN_SYNC_EN, ch0 D=6 and ch1 D=9 running skewed, SyncStart pulse → both counters 0. Ch0 Ticks at +6, +12; ch1 Ticks at +9; coincident Tick at +18.

Source files
------------

// File: rtl/tickgen_pkg.sv
// Shared constants, types and helpers for the multi-channel tick generator.
package tickgen_pkg;

    localparam int TG_CNT_W       = 32;
    localparam int TG_DEFAULT_DIV = 100_000_000;

    typedef enum logic {
        PULSE,
        LEVEL
    } tickgen_mode_t;

    // A divisor of 0 behaves like 1: tick every cycle.
    function automatic logic [63:0] eff_div(input logic [63:0] d);
        return (d == 64'd0) ? 64'd1 : d;
    endfunction

endpackage

// File: rtl/tick_generator_multi_channel.sv
// One tick channel: counter, shadow divisor with pending flag, Tick/Level.
module tick_channel
    import tickgen_pkg::*;
#(
    parameter int CNT_W       = TG_CNT_W,
    parameter int DEFAULT_DIV = TG_DEFAULT_DIV
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             i_en,
    input  logic             i_step,
    input  logic             i_sync,
    input  logic             i_wr,
    input  logic [CNT_W-1:0] i_div,
    output logic             o_tick,
    output logic             o_level,
    output logic [CNT_W-1:0] o_div
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_shadow;
    logic             r_pend;
    logic             r_tick;
    logic             r_level;

    logic [CNT_W-1:0] w_d;
    logic             w_wrap;
    logic             w_load;

    assign w_d    = CNT_W'(eff_div(64'(r_div)));
    assign w_wrap = i_en && (r_cnt == w_d - CNT_W'(1));
    // New divisors only land on a period boundary, or whenever idle.
    assign w_load = r_pend && (i_sync || !i_en || w_wrap);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_cnt    <= '0;
            r_div    <= CNT_W'(DEFAULT_DIV);
            r_shadow <= CNT_W'(DEFAULT_DIV);
            r_pend   <= 1'b0;
            r_tick   <= 1'b0;
            r_level  <= 1'b0;
        end else begin
            if (w_load) begin
                r_div  <= r_shadow;
                r_pend <= 1'b0;
            end
            // A write on the load edge is kept for the following boundary.
            if (i_wr) begin
                r_shadow <= i_div;
                r_pend   <= 1'b1;
            end
            if (i_sync) begin
                r_cnt  <= '0;
                r_tick <= 1'b0;
            end else if (i_en) begin
                if (w_wrap) begin
                    r_cnt   <= '0;
                    r_tick  <= 1'b1;
                    r_level <= ~r_level;
                end else begin
                    r_cnt  <= r_cnt + CNT_W'(1);
                    r_tick <= 1'b0;
                end
            end else begin
                r_cnt  <= '0;
                r_tick <= i_step;
                if (i_step) begin
                    r_level <= ~r_level;
                end
            end
        end
    end

    assign o_tick  = r_tick;
    assign o_level = r_level;
    assign o_div   = r_div;

endmodule

// File: rtl/tick_generator_multi.sv
// Multi-channel programmable tick generator; TICKGEN_SYNC_EN adds SyncStart
// to phase-align all channels.
module tick_generator_multi
    import tickgen_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = TG_CNT_W,
    parameter int DEFAULT_DIV = TG_DEFAULT_DIV,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic [NUM_CH-1:0]       Enable,
    input  logic [NUM_CH-1:0]       Step,
`ifdef TICKGEN_SYNC_EN
    input  logic                    SyncStart,
`endif
    input  logic                    CfgWrite,
    input  logic [CH_W-1:0]         CfgChannel,
    input  logic [CNT_W-1:0]        CfgDivisor,
    output logic [NUM_CH-1:0]       Tick,
    output logic [NUM_CH-1:0]       Level,
    output logic [NUM_CH*CNT_W-1:0] DivActive
);

    logic w_sync;

`ifdef TICKGEN_SYNC_EN
    assign w_sync = SyncStart;
`else
    assign w_sync = 1'b0;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic w_wr;

        // Out-of-range channel numbers match no instance and are dropped.
        assign w_wr = CfgWrite && (CfgChannel == CH_W'(g));

        tick_channel #(
            .CNT_W      (CNT_W),
            .DEFAULT_DIV(DEFAULT_DIV)
        ) u_ch (
            .Clock  (Clock),
            .Reset  (Reset),
            .i_en   (Enable[g]),
            .i_step (Step[g]),
            .i_sync (w_sync),
            .i_wr   (w_wr),
            .i_div  (CfgDivisor),
            .o_tick (Tick[g]),
            .o_level(Level[g]),
            .o_div  (DivActive[g*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_tick_generator_multi.sv
// Randomized + directed bench for tick_generator_multi against a
// period-start reference model.
module tb_tick_generator_multi;

    localparam int          NCH = 4;
    localparam int          CW  = 32;
    localparam logic [31:0] DEF = 32'd10;

    logic           Clock = 1'b0;
    logic           Reset;
    logic [3:0]     Enable;
    logic [3:0]     Step;
    logic           CfgWrite;
    logic [1:0]     CfgChannel;
    logic [31:0]    CfgDivisor;
    logic [3:0]     Tick;
    logic [3:0]     Level;
    logic [127:0]   DivActive;
`ifdef TICKGEN_SYNC_EN
    logic           SyncStart = 1'b0;
`endif

    tick_generator_multi #(
        .NUM_CH     (NCH),
        .CNT_W      (CW),
        .DEFAULT_DIV(int'(DEF))
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Enable    (Enable),
        .Step      (Step),
`ifdef TICKGEN_SYNC_EN
        .SyncStart (SyncStart),
`endif
        .CfgWrite  (CfgWrite),
        .CfgChannel(CfgChannel),
        .CfgDivisor(CfgDivisor),
        .Tick      (Tick),
        .Level     (Level),
        .DivActive (DivActive)
    );

    always #5 Clock = ~Clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: each channel remembers the edge at which its current
    // period began; it ticks when exactly D edges have elapsed since then.
    longint      n;
    longint      mstart[NCH];
    logic [31:0] mdiv[NCH];
    logic [31:0] msh[NCH];
    bit          mpend[NCH];
    bit          mlev[NCH];
    bit          mtick[NCH];

    function automatic bit sync_now();
`ifdef TICKGEN_SYNC_EN
        return SyncStart;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        n = 0;
        for (int i = 0; i < NCH; i++) begin
            mstart[i] = 0;
            mdiv[i]   = DEF;
            msh[i]    = DEF;
            mpend[i]  = 0;
            mlev[i]   = 0;
            mtick[i]  = 0;
        end
    endtask

    task automatic model_step();
        bit     s;
        bit     en;
        bit     wr;
        bit     at_end;
        longint eff;
        n++;
        s = sync_now();
        for (int i = 0; i < NCH; i++) begin
            en     = Enable[i];
            wr     = CfgWrite && (int'(CfgChannel) == i);
            eff    = (mdiv[i] == 0) ? 1 : longint'(mdiv[i]);
            at_end = en && ((n - mstart[i]) == eff);
            if (mpend[i] && (s || !en || at_end)) begin
                mdiv[i]  = msh[i];
                mpend[i] = 0;
            end
            if (wr) begin
                msh[i]   = CfgDivisor;
                mpend[i] = 1;
            end
            if (s) begin
                mstart[i] = n;
                mtick[i]  = 0;
            end else if (en) begin
                mtick[i] = at_end;
                if (at_end) begin
                    mstart[i] = n;
                    mlev[i]   = ~mlev[i];
                end
            end else begin
                mstart[i] = n;
                mtick[i]  = Step[i];
                if (Step[i]) mlev[i] = ~mlev[i];
            end
        end
    endtask

    task automatic check_all();
        logic [3:0]   et;
        logic [3:0]   el;
        logic [127:0] ed;
        for (int i = 0; i < NCH; i++) begin
            et[i]             = mtick[i];
            el[i]             = mlev[i];
            ed[i*32 +: 32]    = mdiv[i];
        end
        chk("tick", Tick, et);
        chk("level", Level, el);
        chk("divactive", DivActive, ed);
    endtask

    task automatic cyc();
        @(posedge Clock);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        Enable     = '0;
        Step       = '0;
        CfgWrite   = 1'b0;
        CfgChannel = '0;
        CfgDivisor = '0;
`ifdef TICKGEN_SYNC_EN
        SyncStart  = 1'b0;
`endif
    endtask

    // Reset asserted between edges, checked while held, released on negedge.
    task automatic do_reset();
        #1;
        Reset = 1'b1;
        #1;
        model_reset();
        check_all();
        idle_inputs();
        @(negedge Clock);
        Reset = 1'b0;
    endtask

    initial begin
        Reset = 1'b1;
        idle_inputs();
        #2;
        model_reset();
        check_all();
        @(negedge Clock);
        Reset = 1'b0;

        // Default divisor 10 on channel 0 only.
        do_reset();
        Enable = 4'b0001;
        for (int c = 1; c <= 30; c++) begin
            cyc();
            if (c % 10 == 0) chk("t1_tick0", Tick, 4'b0001);
        end
        chk("t1_level0", Level, 4'b0001);

        // Reprogram mid-period: old period completes first.
        do_reset();
        Enable = 4'b0001;
        for (int c = 1; c <= 30; c++) begin
            CfgWrite   = (c == 13);
            CfgChannel = 2'd0;
            CfgDivisor = 32'd4;
            cyc();
            if (c == 20 || c == 24 || c == 28) chk("t2_tick0", Tick[0], 1'b1);
            if (c == 16) chk("t2_notick16", Tick[0], 1'b0);
            if (c == 24) chk("t2_div0", DivActive[31:0], 32'd4);
        end
        CfgWrite = 1'b0;

        // Divisors 0 and 1 both tick every cycle.
        do_reset();
        CfgWrite   = 1'b1;
        CfgChannel = 2'd1;
        CfgDivisor = 32'd0;
        cyc();
        CfgWrite = 1'b0;
        cyc();
        chk("t3_div0", DivActive[63:32], 32'd0);
        Enable = 4'b0010;
        for (int c = 0; c < 5; c++) begin
            cyc();
            chk("t3_tick_d0", Tick[1], 1'b1);
        end
        CfgWrite   = 1'b1;
        CfgDivisor = 32'd1;
        cyc();
        CfgWrite = 1'b0;
        cyc();
        chk("t3_div1", DivActive[63:32], 32'd1);
        for (int c = 0; c < 5; c++) begin
            cyc();
            chk("t3_tick_d1", Tick[1], 1'b1);
        end

        // Single-step on a disabled channel.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            Step = 4'b0100;
            cyc();
            chk("t4_step_tick", Tick, 4'b0100);
            Step = 4'b0000;
            cyc();
            chk("t4_step_quiet", Tick[2], 1'b0);
        end
        chk("t4_level2", Level[2], 1'b1);
        Enable = 4'b0100;
        Step   = 4'b0100;
        for (int c = 0; c < 5; c++) begin
            cyc();
            chk("t4_step_ignored", Tick[2], 1'b0);
        end
        Step = 4'b0000;

        // Reset mid-period with a pending write discards everything.
        do_reset();
        Enable = 4'b0001;
        for (int c = 0; c < 6; c++) cyc();
        CfgWrite   = 1'b1;
        CfgChannel = 2'd0;
        CfgDivisor = 32'd3;
        cyc();
        CfgWrite = 1'b0;
        do_reset();
        chk("t5_div_default", DivActive, {4{DEF}});
        Enable = 4'b0001;
        for (int c = 1; c <= 10; c++) begin
            cyc();
            if (c == 3) chk("t5_no_pending", Tick[0], 1'b0);
        end
        chk("t5_tick10", Tick[0], 1'b1);

`ifdef TICKGEN_SYNC_EN
        // Phase alignment of two skewed channels.
        do_reset();
        CfgWrite   = 1'b1;
        CfgChannel = 2'd0;
        CfgDivisor = 32'd6;
        cyc();
        CfgChannel = 2'd1;
        CfgDivisor = 32'd9;
        cyc();
        CfgWrite = 1'b0;
        Enable   = 4'b0001;
        for (int c = 0; c < 4; c++) cyc();
        Enable = 4'b0011;
        for (int c = 0; c < 7; c++) cyc();
        SyncStart = 1'b1;
        cyc();
        SyncStart = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            cyc();
            if (c == 6 || c == 12) chk("t6_tick0", Tick[1:0], 2'b01);
            if (c == 9) chk("t6_tick1", Tick[1:0], 2'b10);
            if (c == 18) chk("t6_both", Tick[1:0], 2'b11);
        end
`endif

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 1000 == 999) do_reset();
            if ($urandom_range(0, 15) == 0) Enable = 4'($urandom);
            Step       = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
            CfgWrite   = ($urandom_range(0, 7) == 0);
            CfgChannel = 2'($urandom);
            CfgDivisor = 32'($urandom_range(0, 12));
`ifdef TICKGEN_SYNC_EN
            SyncStart  = ($urandom_range(0, 49) == 0);
`endif
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
